// File: rtl/thunderbird_monitor.sv
// Receive-side decoder/checker for the six Thunderbird taillight lamps.
// Rebuilds the requested mode, flags illegal patterns/transitions and counts completed sequences.
module thunderbird_monitor #(
  parameter int HOLD_CYCLES = 1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Lc,
  input  logic             Lb,
  input  logic             La,
  input  logic             Ra,
  input  logic             Rb,
  input  logic             Rc,
  output logic [1:0]       mode,
  output logic             active,
  output logic             err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] seq_cnt
);

  localparam int HW = $clog2(HOLD_CYCLES + 2);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_SAT = HW'(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HW_ONE   = HW'(1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_L1, ST_L2, ST_L3, ST_R1, ST_R2, ST_R3, ST_ALL, ST_RESYNC
  } state_t;

  state_t           state_r, state_n, pat_s;
  logic [HW-1:0]    hold_r, hold_n, off_r, off_n;
  logic [1:0]       mode_r, mode_n;
  logic             active_r, active_n, err_r, err_n, sticky_r, sticky_n;
  logic [CNT_W-1:0] cnt_r, cnt_n;
  logic [5:0]       p_s;
  logic             valid_s, is_off_s, trans_ok_s, repeat_s, bad_s;

  // Pattern decode: OFF maps onto the IDLE state
  always_comb begin
    p_s      = {Lc, Lb, La, Ra, Rb, Rc};
    pat_s    = ST_IDLE;
    valid_s  = 1'b1;
    is_off_s = (p_s == 6'b000000);
    case (p_s)
      6'b000000: pat_s = ST_IDLE;
      6'b001000: pat_s = ST_L1;
      6'b011000: pat_s = ST_L2;
      6'b111000: pat_s = ST_L3;
      6'b000100: pat_s = ST_R1;
      6'b000110: pat_s = ST_R2;
      6'b000111: pat_s = ST_R3;
      6'b111111: pat_s = ST_ALL;
      default:   valid_s = 1'b0;
    endcase
  end

  // Legal sequencing table; hazard may pre-empt any running pattern
  always_comb begin
    trans_ok_s = 1'b0;
    case (state_r)
      ST_IDLE: trans_ok_s = (pat_s == ST_IDLE) || (pat_s == ST_L1) ||
                            (pat_s == ST_R1) || (pat_s == ST_ALL);
      ST_L1:   trans_ok_s = (pat_s == ST_L2) || (pat_s == ST_ALL);
      ST_L2:   trans_ok_s = (pat_s == ST_L3) || (pat_s == ST_ALL);
      ST_L3:   trans_ok_s = (pat_s == ST_IDLE) || (pat_s == ST_ALL);
      ST_R1:   trans_ok_s = (pat_s == ST_R2) || (pat_s == ST_ALL);
      ST_R2:   trans_ok_s = (pat_s == ST_R3) || (pat_s == ST_ALL);
      ST_R3:   trans_ok_s = (pat_s == ST_IDLE) || (pat_s == ST_ALL);
      ST_ALL:  trans_ok_s = (pat_s == ST_IDLE);
      default: trans_ok_s = 1'b0;
    endcase
  end

  // Next-state, hold/off counting, error and status outputs
  always_comb begin
    state_n  = state_r;
    hold_n   = hold_r;
    off_n    = off_r;
    mode_n   = mode_r;
    active_n = 1'b0;
    err_n    = 1'b0;
    sticky_n = sticky_r;
    cnt_n    = cnt_r;
    repeat_s = 1'b0;
    bad_s    = 1'b0;
    if (state_r == ST_RESYNC) begin
      hold_n = {HW{1'b0}};
      off_n  = {HW{1'b0}};
      mode_n = 2'b00;
      if (is_off_s) begin
        state_n = ST_IDLE;
      end else begin
        state_n = ST_RESYNC;
      end
    end else begin
      repeat_s = valid_s && !is_off_s && (pat_s == state_r);
      if (!valid_s) begin
        bad_s = 1'b1;
      end else if (repeat_s) begin
        bad_s = (hold_r >= HOLD_MAX);
      end else if ((state_r != ST_IDLE) && (hold_r < HOLD_MAX)) begin
        bad_s = 1'b1;
      end else begin
        bad_s = !trans_ok_s;
      end

      if (bad_s) begin
        err_n    = 1'b1;
        sticky_n = 1'b1;
        mode_n   = 2'b00;
        hold_n   = {HW{1'b0}};
        off_n    = {HW{1'b0}};
        state_n  = is_off_s ? ST_IDLE : ST_RESYNC;
      end else begin
        state_n  = pat_s;
        active_n = !is_off_s;
        if (is_off_s) begin
          hold_n = {HW{1'b0}};
          off_n  = (off_r == HOLD_SAT) ? off_r : off_r + HW_ONE;
        end else begin
          hold_n = repeat_s ? hold_r + HW_ONE : HW_ONE;
          off_n  = {HW{1'b0}};
        end
        case (pat_s)
          ST_L1:   mode_n = 2'b01;
          ST_R1:   mode_n = 2'b10;
          ST_ALL:  mode_n = 2'b11;
          default: mode_n = mode_r;
        endcase
        if (is_off_s && (off_n > HOLD_MAX)) begin
          mode_n = 2'b00;
        end else begin
          mode_n = mode_n;
        end
        // A sequence completes on a legal return to OFF from a terminal pattern
        if (is_off_s && ((state_r == ST_L3) || (state_r == ST_R3) || (state_r == ST_ALL)) &&
            (cnt_r != {CNT_W{1'b1}})) begin
          cnt_n = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_n = cnt_r;
        end
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      hold_r   <= {HW{1'b0}};
      off_r    <= {HW{1'b0}};
      mode_r   <= 2'b00;
      active_r <= 1'b0;
      err_r    <= 1'b0;
      sticky_r <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      state_r  <= state_n;
      hold_r   <= hold_n;
      off_r    <= off_n;
      mode_r   <= mode_n;
      active_r <= active_n;
      err_r    <= err_n;
      sticky_r <= sticky_n;
      cnt_r    <= cnt_n;
    end
  end

  assign mode       = mode_r;
  assign active     = active_r;
  assign err        = err_r;
  assign err_sticky = sticky_r;
  assign seq_cnt    = cnt_r;

endmodule

// File: tb/tb_thunderbird_monitor.sv
// Table-driven self-checking bench for thunderbird_monitor with a scoreboard queue.
module tb_thunderbird_monitor;

  typedef struct {
    logic       rst;
    logic [5:0] p;
    logic [1:0] mode;
    logic       act;
    logic       err;
    logic       sticky;
    logic [7:0] cnt;
  } vec_t;

  localparam logic [5:0] OFF = 6'b000000, L1 = 6'b001000, L2 = 6'b011000, L3 = 6'b111000;
  localparam logic [5:0] R1 = 6'b000100, R2 = 6'b000110, R3 = 6'b000111, ALL = 6'b111111;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic Lc = 1'b1, Lb = 1'b1, La = 1'b1, Ra = 1'b1, Rb = 1'b1, Rc = 1'b1;
  logic [1:0] mode;
  logic active, err, err_sticky;
  logic [7:0] seq_cnt;

  vec_t vecs[$];
  vec_t exp_q[$];
  int checks = 0;
  int passes = 0;
  int vnum = 0;

  thunderbird_monitor #(.HOLD_CYCLES(1), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .Lc(Lc), .Lb(Lb), .La(La), .Ra(Ra), .Rb(Rb), .Rc(Rc),
    .mode(mode), .active(active), .err(err), .err_sticky(err_sticky), .seq_cnt(seq_cnt)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic r, input logic [5:0] p, input logic [1:0] m,
                              input logic a, input logic e, input logic s, input logic [7:0] c);
    vec_t v;
    v.rst = r; v.p = p; v.mode = m; v.act = a; v.err = e; v.sticky = s; v.cnt = c;
    vecs.push_back(v);
  endfunction

  task automatic apply(input vec_t v);
    vec_t x;
    @(negedge clk);
    reset = v.rst;
    {Lc, Lb, La, Ra, Rb, Rc} = v.p;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL vec%0d: scoreboard empty", vnum);
    end else begin
      x = exp_q.pop_front();
      if ({mode, active, err, err_sticky, seq_cnt} === {x.mode, x.act, x.err, x.sticky, x.cnt})
        passes++;
      else
        $display("FAIL vec%0d p=%b: got mode=%b act=%b err=%b sticky=%b cnt=%0d, expected mode=%b act=%b err=%b sticky=%b cnt=%0d",
                 vnum, x.p, mode, active, err, err_sticky, seq_cnt,
                 x.mode, x.act, x.err, x.sticky, x.cnt);
    end
    vnum++;
  endtask

  initial begin
    vec_t v;
    int k;
    // reset held two clocks with all lamps on
    add(1, ALL, 2'b00, 0, 0, 0, 0);
    add(1, ALL, 2'b00, 0, 0, 0, 0);
    // left sequences, mode drops on the second consecutive OFF
    add(0, OFF, 2'b00, 0, 0, 0, 0);
    add(0, L1,  2'b01, 1, 0, 0, 0);
    add(0, L2,  2'b01, 1, 0, 0, 0);
    add(0, L3,  2'b01, 1, 0, 0, 0);
    add(0, OFF, 2'b01, 0, 0, 0, 1);
    add(0, L1,  2'b01, 1, 0, 0, 1);
    add(0, L2,  2'b01, 1, 0, 0, 1);
    add(0, L3,  2'b01, 1, 0, 0, 1);
    add(0, OFF, 2'b01, 0, 0, 0, 2);
    add(0, OFF, 2'b00, 0, 0, 0, 2);
    add(0, OFF, 2'b00, 0, 0, 0, 2);
    // right
    add(0, OFF, 2'b00, 0, 0, 0, 2);
    add(0, R1,  2'b10, 1, 0, 0, 2);
    add(0, R2,  2'b10, 1, 0, 0, 2);
    add(0, R3,  2'b10, 1, 0, 0, 2);
    add(0, OFF, 2'b10, 0, 0, 0, 3);
    // hazard, including L1 pre-empted by ALL
    add(0, ALL, 2'b11, 1, 0, 0, 3);
    add(0, OFF, 2'b11, 0, 0, 0, 4);
    add(0, ALL, 2'b11, 1, 0, 0, 4);
    add(0, OFF, 2'b11, 0, 0, 0, 5);
    add(0, ALL, 2'b11, 1, 0, 0, 5);
    add(0, OFF, 2'b11, 0, 0, 0, 6);
    add(0, L1,  2'b01, 1, 0, 0, 6);
    add(0, ALL, 2'b11, 1, 0, 0, 6);
    add(0, OFF, 2'b11, 0, 0, 0, 7);
    // stall: L1 held twice, then resync
    add(0, OFF, 2'b00, 0, 0, 0, 7);
    add(0, L1,  2'b01, 1, 0, 0, 7);
    add(0, L1,  2'b00, 0, 1, 1, 7);
    add(0, L2,  2'b00, 0, 0, 1, 7);
    add(0, OFF, 2'b00, 0, 0, 1, 7);
    // illegal code, then reset in the middle of a right sequence
    add(0, 6'b001100, 2'b00, 0, 1, 1, 7);
    add(0, OFF, 2'b00, 0, 0, 1, 7);
    add(0, R1,  2'b10, 1, 0, 1, 7);
    add(0, R2,  2'b10, 1, 0, 1, 7);
    add(1, R3,  2'b00, 0, 0, 0, 0);
    add(0, R1,  2'b10, 1, 0, 0, 0);
    add(0, R2,  2'b10, 1, 0, 0, 0);
    add(0, R3,  2'b10, 1, 0, 0, 0);
    add(0, OFF, 2'b10, 0, 0, 0, 1);
    // illegal transition from idle, then hazard held too long
    add(0, L2,  2'b00, 0, 1, 1, 1);
    add(0, OFF, 2'b00, 0, 0, 1, 1);
    add(0, ALL, 2'b11, 1, 0, 1, 1);
    add(0, ALL, 2'b00, 0, 1, 1, 1);
    add(0, OFF, 2'b00, 0, 0, 1, 1);
    add(0, R1,  2'b10, 1, 0, 1, 1);
    add(0, L2,  2'b00, 0, 1, 1, 1);
    add(0, OFF, 2'b00, 0, 0, 1, 1);

    foreach (vecs[i]) apply(vecs[i]);

    // saturation of seq_cnt: 260 hazard sequences after a fresh reset
    v.rst = 1; v.p = ALL; v.mode = 2'b00; v.act = 0; v.err = 0; v.sticky = 0; v.cnt = 0;
    apply(v);
    for (k = 1; k <= 260; k++) begin
      v.rst = 0; v.p = ALL; v.mode = 2'b11; v.act = 1; v.err = 0; v.sticky = 0;
      v.cnt = (k - 1 > 255) ? 8'd255 : 8'(k - 1);
      apply(v);
      v.p = OFF; v.act = 0;
      v.cnt = (k > 255) ? 8'd255 : 8'(k);
      apply(v);
    end

    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
